// File: rtl/btn_event_arbiter.sv
// Round-robin arbiter that queues one pending press per button and serialises
// them onto a valid/ready command stream, with an idle lockout after each accept.
module btn_event_arbiter #(
  parameter int N_BTN       = 4,
  parameter int LOCKOUT_CYC = 100,
  localparam int ID_W       = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] i_btn_pulse,
  input  logic             i_ready,
  input  logic             i_clr_overrun,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_btn_id,
  output logic [N_BTN-1:0] o_pending,
  output logic [N_BTN-1:0] o_overrun
);

  // state   | meaning
  // IDLE    | waiting for a pending press, arbitrates when one exists
  // OFFER   | o_valid high, granted id held until accepted
  // HOLDOFF | lockout gap after an accept, presses still queue
  typedef enum logic [1:0] {IDLE, OFFER, HOLDOFF} state_t;

  localparam int CNT_W = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOCKOUT_CYC > 0) ? LOCKOUT_CYC - 1 : 0);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_BTN-1:0]   pend_q, pend_d;
  logic [N_BTN-1:0]   ovr_q, ovr_d;
  logic [N_BTN-1:0]   clr_mask;
  logic               accept;
  logic               found;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W:0]      sum;

  assign o_valid   = (state_q == OFFER);
  assign o_btn_id  = id_q;
  assign o_pending = pend_q;
  assign o_overrun = ovr_q;
  assign accept    = o_valid & i_ready;
  assign clr_mask  = accept ? (N_BTN'(1) << id_q) : '0;

  // Search starts one past the last grant and wraps, so every button gets a turn.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    sum      = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      sum = {1'b0, last_q} + (ID_W + 1)'(k);
      if (sum >= (ID_W + 1)'(N_BTN)) sum = sum - (ID_W + 1)'(N_BTN);
      if (!found && pend_q[sum[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    pend_d = (pend_q & ~clr_mask) | i_btn_pulse;
    ovr_d  = (i_clr_overrun ? '0 : ovr_q) | (i_btn_pulse & pend_q & ~clr_mask);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = grant_id;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          last_d  = id_q;
          state_d = (LOCKOUT_CYC > 0) ? HOLDOFF : IDLE;
        end
      end
      HOLDOFF: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= ID_W'(N_BTN - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Scoreboard bench for btn_event_arbiter: directed presses push expected ids,
// a negedge monitor pops and compares on every accepted event.
module tb_btn_event_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] i_btn_pulse = '0;
  logic       i_ready = 1'b0;
  logic       i_clr_overrun = 1'b0;
  logic       o_valid;
  logic [1:0] o_btn_id;
  logic [3:0] o_pending;
  logic [3:0] o_overrun;

  int n_checks = 0;
  int n_pass = 0;
  int exp_q[$];

  btn_event_arbiter #(.N_BTN(4), .LOCKOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .i_btn_pulse(i_btn_pulse), .i_ready(i_ready),
    .i_clr_overrun(i_clr_overrun), .o_valid(o_valid), .o_btn_id(o_btn_id),
    .o_pending(o_pending), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_btn_pulse = '0;
    i_ready = 1'b0;
    i_clr_overrun = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // monitor: every accepted event must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && o_valid && i_ready) begin
      if (exp_q.size() == 0) chk("unexpected_event_id", int'(o_btn_id), -1);
      else chk("event_id", int'(o_btn_id), exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises[$];
    bit prev;
    int n;
    int fair_ids[5] = '{0, 1, 0, 1, 0};

    // 1: reset holds everything clear even with all buttons pressed
    reset = 1'b1;
    i_btn_pulse = 4'hF;
    repeat (3) tick();
    reset = 1'b0;
    i_btn_pulse = '0;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_pending", int'(o_pending), 0);
    chk("rst_overrun", int'(o_overrun), 0);
    tick();
    chk("rst_pending_after", int'(o_pending), 0);
    chk("rst_id", int'(o_btn_id), 0);

    // 2: single press, offered exactly one cycle with ready high
    do_reset();
    i_ready = 1'b1;
    i_btn_pulse = 4'b0100;
    exp_q.push_back(2);
    tick();
    i_btn_pulse = '0;
    chk("single_pending_set", int'(o_pending), 4'b0100);
    chk("single_valid_early", int'(o_valid), 0);
    tick();
    chk("single_valid", int'(o_valid), 1);
    chk("single_id", int'(o_btn_id), 2);
    tick();
    chk("single_valid_drop", int'(o_valid), 0);
    chk("single_pending_clr", int'(o_pending), 0);
    repeat (8) tick();
    chk("single_sb_empty", exp_q.size(), 0);

    // 3: burst, ids 0,1,3 with valid rises 6 cycles apart
    do_reset();
    i_ready = 1'b1;
    i_btn_pulse = 4'b1011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      i_btn_pulse = '0;
      if (o_valid && !prev) rises.push_back(c);
      prev = o_valid;
    end
    chk("burst_rises", rises.size(), 3);
    if (rises.size() == 3) begin
      chk("burst_gap0", rises[1] - rises[0], 6);
      chk("burst_gap1", rises[2] - rises[1], 6);
    end
    chk("burst_sb_empty", exp_q.size(), 0);

    // 4: fairness, each accepted button re-pressed in its accept cycle
    do_reset();
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(fair_ids[i]);
    i_btn_pulse = 4'b0011;
    tick();
    i_btn_pulse = '0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!o_valid && n < 30) begin
        tick();
        n++;
      end
      if (!o_valid) chk("fair_timeout", 0, 1);
      else begin
        if (i < 3) i_btn_pulse = 4'(1) << fair_ids[i];
        tick();
        i_btn_pulse = '0;
      end
    end
    repeat (10) tick();
    chk("fair_sb_empty", exp_q.size(), 0);
    chk("fair_overrun", int'(o_overrun), 0);
    chk("fair_pending", int'(o_pending), 0);

    // 5: overrun on a second press while pending, one event only
    do_reset();
    i_btn_pulse = 4'b0010;
    exp_q.push_back(1);
    tick();
    i_btn_pulse = '0;
    repeat (3) tick();
    chk("ovr_before", int'(o_overrun), 0);
    i_btn_pulse = 4'b0010;
    tick();
    i_btn_pulse = '0;
    chk("ovr_set", int'(o_overrun), 4'b0010);
    chk("ovr_pending", int'(o_pending), 4'b0010);
    chk("ovr_valid_held", int'(o_valid), 1);
    i_ready = 1'b1;
    repeat (15) tick();
    chk("ovr_sb_empty", exp_q.size(), 0);
    chk("ovr_sticky", int'(o_overrun), 4'b0010);
    i_clr_overrun = 1'b1;
    tick();
    i_clr_overrun = 1'b0;
    chk("ovr_cleared", int'(o_overrun), 0);

    // 6: reset during OFFER and during HOLDOFF
    do_reset();
    i_btn_pulse = 4'b0100;
    tick();
    i_btn_pulse = '0;
    tick();
    chk("mid_offer_valid", int'(o_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_offer_rst_valid", int'(o_valid), 0);
    chk("mid_offer_rst_pending", int'(o_pending), 0);
    i_ready = 1'b1;
    i_btn_pulse = 4'b0010;
    exp_q.push_back(1);
    tick();
    i_btn_pulse = '0;
    tick();
    tick();
    chk("holdoff_valid", int'(o_valid), 0);
    i_btn_pulse = 4'b0001;
    tick();
    i_btn_pulse = '0;
    chk("holdoff_pending", int'(o_pending), 4'b0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_hold_rst_valid", int'(o_valid), 0);
    chk("mid_hold_rst_pending", int'(o_pending), 0);
    i_btn_pulse = 4'b1000;
    exp_q.push_back(3);
    tick();
    i_btn_pulse = '0;
    tick();
    chk("post_rst_valid", int'(o_valid), 1);
    chk("post_rst_id", int'(o_btn_id), 3);
    repeat (10) tick();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
